rf_multiport_sb: RTL and testbench
==================================

Name: rf_multiport_sb

Overview:
- Parametrised successor to the single-write integer register file. Sits between decode/issue and writeback in the RISC-V core.
- Provides NRD combinational read ports with same-cycle write bypass and two write ports with fixed priority.
- x0 is hardwired to zero. An asynchronous clear initialises all registers.
- Includes a busy-bit scoreboard: issue marks a destination register pending; writeback clears it. Issue logic uses the scoreboard for RAW/WAW hazard stalls.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, min 2).
- AW, $clog2(NREGS), register address width.
- NRD, 2, number of read ports (1..4).
- RST_VAL, 0, value loaded into every register on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  packed read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data.
- rd_busy  out  NRD  scoreboard busy bit for each read address.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1.
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- iss_valid  in  1  an instruction issues and will write iss_rd.
- iss_rd  in  AW  destination of the issuing instruction.
- iss_busy  out  1  busy bit of iss_rd (for WAW check).
- any_busy  out  1  OR of all busy bits (for pipeline drain/flush).

Behaviour:
- Reset (asynchronous, while rst=1):
  - All registers are set to RST_VAL (register 0 stays 0) and all busy bits are cleared.
  - Combinational outputs follow: rd_data reads RST_VAL, except address 0 reads 0; all busy outputs are 0.
  - After rst deasserts, the first edge can perform writes.
- Reads (combinational, zero latency):
  - Address 0 always returns 0 and rd_busy=0.
  - Otherwise, priority is: we1 && wa1==addr returns wd1; else we0 && wa0==addr returns wd0; else the stored value.
  - This write-through bypass hides the one-cycle writeback-to-read gap.
- Writes (at the clock edge):
  - Writes to address 0 are ignored.
  - If we0 && we1 && wa0==wa1, port 1 wins and wd0 is discarded.
  - Writes to different addresses both commit in the same edge.
- Scoreboard (one bit per register; bit 0 is constant 0):
  - Clear: any write (we0 or we1) to register r clears busy[r].
  - Set: iss_valid with iss_rd=r (r≠0) sets busy[r].
  - Set and clear of the same r in the same cycle: set wins, because the new producer supersedes the one retiring.
  - iss_valid with iss_rd=0 has no effect.
  - Writes to registers that are not busy are legal and leave the bit cleared.
- rd_busy and iss_busy reflect the registered busy state only. There is no bypass of a same-cycle clear into the busy outputs; the conservative stall costs one cycle at most.
- any_busy is registered-state OR, combinational on the output.
- Reset mid-operation: in-flight writes in the reset cycle are lost; the scoreboard clears.

Decomposition:
- Package riscv_rf_pkg holds:
  - XLEN, NREGS and AW defaults.
  - The REG_ZERO constant (address 0).
  - Function reg_bypass(addr, we0, wa0, wd0, we1, wa1, wd1, stored), shared with the floating-point file later.
- Sub-module rf_scoreboard (NREGS, AW) holds:
  - the busy vector;
  - set/clear logic;
  - NRD+1 lookup outputs;
  - any_busy.
- The top level instantiates rf_scoreboard alongside the storage array and generates the read ports.

Test Plan:
1. Reset: hold rst=1, then release. Reading addresses 0, 5 and 31 returns 0; rd_busy=0; any_busy=0.
2. Write/read with x0:
   - we0=1, wa0=5, wd0=0xDEADBEEF. Same cycle, rd_addr[0]=5 → rd_data[0]=0xDEADBEEF via bypass. The next cycle still reads 0xDEADBEEF.
   - we0=1, wa0=0, wd0=0x1234. Reading address 0 returns 0.
3. Port collision: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 → register 7 holds 0x22. A separate cycle with wa0=3, wa1=4 commits both.
4. Scoreboard lifecycle:
   - iss_valid with iss_rd=9 → next cycle rd_busy=1 for address 9, iss_busy=1 when iss_rd=9, any_busy=1.
   - we1 to wa1=9 → busy clears the following cycle and any_busy=0.
5. Simultaneous set/clear: busy[12]=1, then in one cycle we0 to 12 and iss_valid with iss_rd=12 → busy[12] stays 1 and register 12 is updated with the write data.
6. Async reset mid-run: with busy bits 3 and 9 set and register 5=0xA5, pulse rst between clock edges → outputs clear immediately without waiting for a clock edge (register 5 reads 0, any_busy=0).

Source files
------------

// File: rtl/riscv_rf_pkg.sv
// Shared definitions for the integer (and later floating-point) register files:
// default geometry, the zero-register address and the write-through read helper.
package riscv_rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_AW    = $clog2(RF_NREGS);

    // The bypass helper works on the widest supported shape; callers zero-extend
    // into it and truncate the result back to their own XLEN.
    localparam int BYP_DW = 64;
    localparam int BYP_AW = 8;

    localparam logic [BYP_AW-1:0] REG_ZERO = '0;

    function automatic logic [BYP_DW-1:0] reg_bypass(
        input logic [BYP_AW-1:0] addr,
        input logic              we0,
        input logic [BYP_AW-1:0] wa0,
        input logic [BYP_DW-1:0] wd0,
        input logic              we1,
        input logic [BYP_AW-1:0] wa1,
        input logic [BYP_DW-1:0] wd1,
        input logic [BYP_DW-1:0] stored
    );
        logic [BYP_DW-1:0] result;
        if (addr == REG_ZERO) begin
            result = '0;
        end else if (we1 && (wa1 == addr)) begin
            result = wd1;
        end else if (we0 && (wa0 == addr)) begin
            result = wd0;
        end else begin
            result = stored;
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, any writeback clears it.
// Lookups and any_busy see registered state only.
module rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS),
    parameter int NLK   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [NLK*AW-1:0] lk_addr,
    output logic [NLK-1:0]    lk_busy,
    output logic              any_busy
);

    logic [NREGS-1:0] busy_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_vec[gi] = 1'b0;
            end else begin : g_bit
                logic busy_reg;
                // A new producer supersedes the one retiring, so set beats clear.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        busy_reg <= 1'b0;
                    end else if (iss_valid && (iss_rd == AW'(gi))) begin
                        busy_reg <= 1'b1;
                    end else if ((we0 && (wa0 == AW'(gi))) || (we1 && (wa1 == AW'(gi)))) begin
                        busy_reg <= 1'b0;
                    end
                end
                assign busy_vec[gi] = busy_reg;
            end
        end

        for (gi = 0; gi < NLK; gi++) begin : g_lookup
            assign lk_busy[gi] = busy_vec[lk_addr[gi*AW +: AW]];
        end
    endgenerate

    assign any_busy = |busy_vec;

endmodule

// File: rtl/rf_multiport_sb.sv
// Integer register file: NRD bypassed read ports, two prioritised write ports
// (port 1 wins on collision), hardwired x0 and a busy-bit scoreboard.
module rf_multiport_sb
    import riscv_rf_pkg::*;
#(
    parameter int              XLEN    = RF_XLEN,
    parameter int              NREGS   = RF_NREGS,
    parameter int              AW      = $clog2(NREGS),
    parameter int              NRD     = 2,
    parameter logic [XLEN-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [XLEN-1:0]   wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [XLEN-1:0]   wd1,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_busy,
    output logic              any_busy
);

    logic [XLEN-1:0] reg_view [NREGS];
    logic [NRD:0]    lk_busy;

    genvar gi;
    generate
        // x0 has no storage; writes to it fall through every comparator.
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_view[gi] = '0;
            end else begin : g_store
                logic [XLEN-1:0] q_reg;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        q_reg <= RST_VAL;
                    end else if (we1 && (wa1 == AW'(gi))) begin
                        q_reg <= wd1;
                    end else if (we0 && (wa0 == AW'(gi))) begin
                        q_reg <= wd0;
                    end
                end
                assign reg_view[gi] = q_reg;
            end
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            assign addr = rd_addr[gi*AW +: AW];
            assign rd_data[gi*XLEN +: XLEN] = XLEN'(reg_bypass(
                BYP_AW'(addr),
                we0, BYP_AW'(wa0), BYP_DW'(wd0),
                we1, BYP_AW'(wa1), BYP_DW'(wd1),
                BYP_DW'(reg_view[addr])));
            assign rd_busy[gi] = lk_busy[gi];
        end
    endgenerate

    // Lookup slot NRD is the issuing destination, used for the WAW check.
    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .NLK   (NRD + 1)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we0       (we0),
        .wa0       (wa0),
        .we1       (we1),
        .wa1       (wa1),
        .lk_addr   ({iss_rd, rd_addr}),
        .lk_busy   (lk_busy),
        .any_busy  (any_busy)
    );

    assign iss_busy = lk_busy[NRD];

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench for rf_multiport_sb: directed scenarios plus randomized
// traffic compared against an array/bit-vector model of the register file.
module tb_rf_multiport_sb;

    localparam int              XLEN    = 32;
    localparam int              NREGS   = 32;
    localparam int              AW      = 5;
    localparam int              NRD     = 2;
    localparam logic [XLEN-1:0] RST_VAL = 32'hC0DE_0001;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we0, we1, iss_valid;
    logic [AW-1:0]       wa0, wa1, iss_rd;
    logic [XLEN-1:0]     wd0, wd1;
    logic                iss_busy, any_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [XLEN-1:0] mdl_mem  [NREGS];
    bit              mdl_busy [NREGS];

    rf_multiport_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .RST_VAL(RST_VAL)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_busy(iss_busy), .any_busy(any_busy)
    );

    always #5 clk = ~clk;

    function automatic void init_model();
        for (int i = 0; i < NREGS; i++) begin
            mdl_mem[i]  = (i == 0) ? '0 : RST_VAL;
            mdl_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return mdl_mem[a];
    endfunction

    function automatic bit exp_any();
        for (int i = 0; i < NREGS; i++) if (mdl_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_idle();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        iss_valid = 0; iss_rd = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    // Advance one rising edge, apply it to the model, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (we1 && wa1 != 0) mdl_mem[wa1] = wd1;
            if (we0 && wa0 != 0 && !(we1 && wa1 == wa0)) mdl_mem[wa0] = wd0;
            if (we0) mdl_busy[wa0] = 1'b0;
            if (we1) mdl_busy[wa1] = 1'b0;
            if (iss_valid && iss_rd != 0) mdl_busy[iss_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; set_idle();
        set_rd(0, 5); set_rd(1, 0);
        #2;
        tests_run++;
        if (rd_data[0 +: XLEN] !== RST_VAL) begin
            tests_failed++; $display("FAIL reset_rd5: got %h expected %h", rd_data[0 +: XLEN], RST_VAL);
        end
        tests_run++;
        if (rd_data[XLEN +: XLEN] !== '0) begin
            tests_failed++; $display("FAIL reset_rd0: got %h expected 0", rd_data[XLEN +: XLEN]);
        end
        tests_run++;
        if (rd_busy !== '0 || any_busy !== 1'b0 || iss_busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy: got rd_busy=%b any=%b iss=%b expected 0", rd_busy, any_busy, iss_busy);
        end
        @(negedge clk);
        rst = 0; init_model();
        set_rd(0, 31);
        #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== RST_VAL) begin
            tests_failed++; $display("FAIL reset_rd31: got %h expected %h", rd_data[0 +: XLEN], RST_VAL);
        end
        $display("[TB] reset: rd5/rd0/rd31 and busy outputs checked");
        @(negedge clk);
    endtask

    task automatic test_write_read();
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; set_rd(0, 5);
        #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL bypass_wr5: got %h expected deadbeef", rd_data[0 +: XLEN]);
        end
        tick(); set_idle(); #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL stored_wr5: got %h expected deadbeef", rd_data[0 +: XLEN]);
        end
        @(negedge clk);
        we0 = 1; wa0 = 0; wd0 = 32'h1234; set_rd(0, 0);
        #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== '0) begin
            tests_failed++; $display("FAIL x0_bypass: got %h expected 0", rd_data[0 +: XLEN]);
        end
        tick(); set_idle(); #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== '0) begin
            tests_failed++; $display("FAIL x0_stored: got %h expected 0", rd_data[0 +: XLEN]);
        end
        $display("[TB] write_read: x5 bypass/stored and x0 write ignored");
        @(negedge clk);
    endtask

    task automatic test_collision();
        we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; set_rd(0, 7);
        #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== 32'h22) begin
            tests_failed++; $display("FAIL collide_bypass: got %h expected 22", rd_data[0 +: XLEN]);
        end
        tick(); set_idle(); #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== 32'h22) begin
            tests_failed++; $display("FAIL collide_stored: got %h expected 22", rd_data[0 +: XLEN]);
        end
        @(negedge clk);
        we0 = 1; wa0 = 3; wd0 = 32'h33; we1 = 1; wa1 = 4; wd1 = 32'h44;
        tick(); set_idle(); set_rd(0, 3); set_rd(1, 4); #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== 32'h33 || rd_data[XLEN +: XLEN] !== 32'h44) begin
            tests_failed++; $display("FAIL dual_write: got %h/%h expected 33/44", rd_data[0 +: XLEN], rd_data[XLEN +: XLEN]);
        end
        $display("[TB] collision: port1 priority and dual commit");
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_rd = 9;
        tick(); set_idle(); iss_rd = 9; set_rd(0, 9); #1;
        tests_run++;
        if (rd_busy[0] !== 1'b1 || iss_busy !== 1'b1 || any_busy !== 1'b1) begin
            tests_failed++; $display("FAIL sb_set: got rd=%b iss=%b any=%b expected 1/1/1", rd_busy[0], iss_busy, any_busy);
        end
        @(negedge clk);
        we1 = 1; wa1 = 9; wd1 = 32'h99; #1;
        tests_run++;
        if (rd_busy[0] !== 1'b1) begin
            tests_failed++; $display("FAIL sb_no_bypass: got %b expected 1", rd_busy[0]);
        end
        tick(); set_idle(); iss_rd = 9; #1;
        tests_run++;
        if (rd_busy[0] !== 1'b0 || iss_busy !== 1'b0 || any_busy !== 1'b0) begin
            tests_failed++; $display("FAIL sb_clear: got rd=%b iss=%b any=%b expected 0/0/0", rd_busy[0], iss_busy, any_busy);
        end
        $display("[TB] scoreboard: x9 set, held through writeback cycle, cleared");
        @(negedge clk);
    endtask

    task automatic test_set_clear();
        iss_valid = 1; iss_rd = 12;
        tick(); set_idle();
        we0 = 1; wa0 = 12; wd0 = 32'hCAFEF00D; iss_valid = 1; iss_rd = 12;
        tick(); set_idle(); set_rd(0, 12); #1;
        tests_run++;
        if (rd_busy[0] !== 1'b1) begin
            tests_failed++; $display("FAIL setclr_busy: got %b expected 1", rd_busy[0]);
        end
        tests_run++;
        if (rd_data[0 +: XLEN] !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL setclr_data: got %h expected cafef00d", rd_data[0 +: XLEN]);
        end
        $display("[TB] set_clear: x12 stays busy and takes write data");
        @(negedge clk);
        we0 = 1; wa0 = 12; wd0 = 32'h0;
        tick(); set_idle();
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = tests_failed;
        for (int c = 0; c < 400; c++) begin
            logic [AW-1:0] a;
            we0 = 1'($urandom); wa0 = AW'($urandom_range(0, 7)); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = AW'($urandom_range(0, 7)); wd1 = $urandom;
            if ($urandom_range(0, 3) == 0) wa1 = AW'($urandom);
            iss_valid = ($urandom_range(0, 2) != 0); iss_rd = AW'($urandom_range(0, 9));
            for (int p = 0; p < NRD; p++) set_rd(p, AW'($urandom_range(0, 9)));
            #1;
            for (int p = 0; p < NRD; p++) begin
                a = rd_addr[p*AW +: AW];
                tests_run++;
                if (rd_data[p*XLEN +: XLEN] !== exp_read(a)) begin
                    tests_failed++; $display("FAIL rand_data c%0d p%0d a%0d: got %h expected %h", c, p, a, rd_data[p*XLEN +: XLEN], exp_read(a));
                end
                tests_run++;
                if (rd_busy[p] !== mdl_busy[a]) begin
                    tests_failed++; $display("FAIL rand_busy c%0d p%0d a%0d: got %b expected %b", c, p, a, rd_busy[p], mdl_busy[a]);
                end
            end
            tests_run++;
            if (iss_busy !== mdl_busy[iss_rd] || any_busy !== exp_any()) begin
                tests_failed++; $display("FAIL rand_iss c%0d: got iss=%b any=%b expected %b/%b", c, iss_busy, any_busy, mdl_busy[iss_rd], exp_any());
            end
            tick();
        end
        set_idle();
        $display("[TB] random: 400 cycles, %0d new failures", tests_failed - errs_before);
    endtask

    task automatic test_async_reset();
        iss_valid = 1; iss_rd = 3; we0 = 1; wa0 = 5; wd0 = 32'hA5;
        tick(); set_idle();
        iss_valid = 1; iss_rd = 9;
        tick(); set_idle();
        iss_rd = 3; set_rd(0, 5); set_rd(1, 9); #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== 32'hA5 || any_busy !== 1'b1 || rd_busy[1] !== 1'b1) begin
            tests_failed++; $display("FAIL arst_setup: got %h any=%b b9=%b expected a5/1/1", rd_data[0 +: XLEN], any_busy, rd_busy[1]);
        end
        #2 rst = 1;
        #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== RST_VAL) begin
            tests_failed++; $display("FAIL arst_data: got %h expected %h", rd_data[0 +: XLEN], RST_VAL);
        end
        tests_run++;
        if (any_busy !== 1'b0 || rd_busy !== '0 || iss_busy !== 1'b0) begin
            tests_failed++; $display("FAIL arst_busy: got any=%b rd=%b iss=%b expected 0", any_busy, rd_busy, iss_busy);
        end
        we0 = 1; wa0 = 6; wd0 = 32'hFFFF;
        @(negedge clk);
        rst = 0; set_idle(); init_model();
        set_rd(0, 6); #1;
        tests_run++;
        if (rd_data[0 +: XLEN] !== RST_VAL) begin
            tests_failed++; $display("FAIL arst_lost_write: got %h expected %h", rd_data[0 +: XLEN], RST_VAL);
        end
        $display("[TB] async_reset: immediate clear, write during reset dropped");
        @(negedge clk);
    endtask

    initial begin
        rd_addr = '0;
        init_model();
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_set_clear();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
